alu_serial_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_ctrl_decode.sv | 29 ++
 rtl/alu_top.sv | 37 +++
 rtl/alu_serial_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings, decode payload and FSM state for the bit-serial ALU sequencer.
package alu_pkg;

   // alu_ctrl request codes
   localparam logic [3:0] CTRL_AND = 4'b0000;
   localparam logic [3:0] CTRL_OR  = 4'b0001;
   localparam logic [3:0] CTRL_ADD = 4'b0010;
   localparam logic [3:0] CTRL_SUB = 4'b0110;
   localparam logic [3:0] CTRL_SLT = 4'b0111;
   localparam logic [3:0] CTRL_NOR = 4'b1100;

   // 1-bit slice operation select
   localparam logic [1:0] SOP_AND  = 2'b00;
   localparam logic [1:0] SOP_OR   = 2'b01;
   localparam logic [1:0] SOP_ADD  = 2'b10;
   localparam logic [1:0] SOP_LESS = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Decoded control word, latched at accept
   typedef struct packed {
      logic       a_invert;
      logic       b_invert;
      logic       cin0;
      logic [1:0] operation;
      logic       is_arith;
      logic       is_slt;
      logic       is_valid;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps a 4-bit alu_ctrl code to slice controls and operation class.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [3:0] alu_ctrl_i,
   output dec_t       dec_o
);

   // Unsupported codes fall through with is_valid = 0 and all drives low
   always_comb begin
      dec_o = '0;
      case (alu_ctrl_i)
         CTRL_AND: dec_o = '{a_invert: 1'b0, b_invert: 1'b0, cin0: 1'b0, operation: SOP_AND,
                             is_arith: 1'b0, is_slt: 1'b0, is_valid: 1'b1};
         CTRL_OR:  dec_o = '{a_invert: 1'b0, b_invert: 1'b0, cin0: 1'b0, operation: SOP_OR,
                             is_arith: 1'b0, is_slt: 1'b0, is_valid: 1'b1};
         CTRL_ADD: dec_o = '{a_invert: 1'b0, b_invert: 1'b0, cin0: 1'b0, operation: SOP_ADD,
                             is_arith: 1'b1, is_slt: 1'b0, is_valid: 1'b1};
         CTRL_SUB: dec_o = '{a_invert: 1'b0, b_invert: 1'b1, cin0: 1'b1, operation: SOP_ADD,
                             is_arith: 1'b1, is_slt: 1'b0, is_valid: 1'b1};
         CTRL_SLT: dec_o = '{a_invert: 1'b0, b_invert: 1'b1, cin0: 1'b1, operation: SOP_ADD,
                             is_arith: 1'b1, is_slt: 1'b1, is_valid: 1'b1};
         CTRL_NOR: dec_o = '{a_invert: 1'b1, b_invert: 1'b1, cin0: 1'b0, operation: SOP_AND,
                             is_arith: 1'b0, is_slt: 1'b0, is_valid: 1'b1};
         default:  dec_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_top.sv
// Combinational 1-bit ALU slice driven by the serial sequencer.
module alu_top
   import alu_pkg::*;
(
   input  logic       src1,
   input  logic       src2,
   input  logic       less,
   input  logic       a_invert,
   input  logic       b_invert,
   input  logic       cin,
   input  logic [1:0] operation,
   output logic       result,
   output logic       cout
);

   logic a_c;
   logic b_c;

   assign a_c = src1 ^ a_invert;
   assign b_c = src2 ^ b_invert;

   // Full-adder carry is produced for every operation
   assign cout = (a_c & b_c) | (a_c & cin) | (b_c & cin);

   // Result mux on the selected operation
   always_comb begin
      result = 1'b0;
      case (operation)
         SOP_AND:  result = a_c & b_c;
         SOP_OR:   result = a_c | b_c;
         SOP_ADD:  result = a_c ^ b_c ^ cin;
         SOP_LESS: result = less;
         default:  result = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: steps an external 1-bit ALU slice LSB first and
// rebuilds the WIDTH-bit result and flags.
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       alu_ctrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow,
   output logic             slice_src1,
   output logic             slice_src2,
   output logic             slice_less,
   output logic             slice_a_invert,
   output logic             slice_b_invert,
   output logic             slice_cin,
   output logic [1:0]       slice_operation,
   input  logic             slice_result,
   input  logic             slice_cout
);

   localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   op1_q, op1_d;
   logic [WIDTH-1:0]   op2_q, op2_d;
   logic [WIDTH-1:0]   res_sh_q, res_sh_d;
   logic               carry_q, carry_d;
   logic               ainv_q, ainv_d;
   logic               binv_q, binv_d;
   logic [1:0]         sop_q, sop_d;
   logic               arith_q, arith_d;
   logic               slt_q, slt_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   dec_t               dec_c;
   logic               accept_c;
   logic               last_c;
   logic [WIDTH-1:0]   res_new_c;
   logic [WIDTH-1:0]   final_c;
   logic               ovf_c;

   alu_ctrl_decode u_dec (
      .alu_ctrl_i (alu_ctrl),
      .dec_o      (dec_c)
   );

   assign accept_c = (state_q == ST_IDLE) && start;
   assign last_c   = (idx_q == IDX_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: one RUN cycle per bit, return to IDLE after the MSB
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)  state_d = ST_RUN;
         ST_RUN:  if (last_c) state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   // Datapath/output next values: latch on accept, shift per bit, resolve flags at the MSB
   always_comb begin
      idx_d     = idx_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      res_sh_d  = res_sh_q;
      carry_d   = carry_q;
      ainv_d    = ainv_q;
      binv_d    = binv_q;
      sop_d     = sop_q;
      arith_d   = arith_q;
      slt_d     = slt_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      result_d  = result_q;
      zero_d    = zero_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      res_new_c = {slice_result, res_sh_q[WIDTH-1:1]};
      ovf_c     = arith_q & (carry_q ^ slice_cout);
      final_c   = '0;

      if (accept_c) begin
         idx_d    = '0;
         op1_d    = src1;
         op2_d    = src2;
         res_sh_d = '0;
         carry_d  = dec_c.cin0;
         ainv_d   = dec_c.a_invert;
         binv_d   = dec_c.b_invert;
         sop_d    = dec_c.operation;
         arith_d  = dec_c.is_arith;
         slt_d    = dec_c.is_slt;
         valid_d  = dec_c.is_valid;
         busy_d   = 1'b1;
      end else if (state_q == ST_RUN) begin
         // Operands shift in zeros so the slice inputs settle to 0 once idle
         res_sh_d = res_new_c;
         op1_d    = {1'b0, op1_q[WIDTH-1:1]};
         op2_d    = {1'b0, op2_q[WIDTH-1:1]};
         carry_d  = slice_cout;
         idx_d    = idx_q + IDX_W'(1);
         if (last_c) begin
            if (!valid_q)   final_c = '0;
            else if (slt_q) final_c = {{(WIDTH-1){1'b0}}, slice_result ^ ovf_c};
            else            final_c = res_new_c;
            idx_d    = '0;
            carry_d  = 1'b0;
            ainv_d   = 1'b0;
            binv_d   = 1'b0;
            sop_d    = SOP_AND;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            result_d = final_c;
            zero_d   = (final_c == '0);
            cout_d   = arith_q & slice_cout;
            ovf_d    = ovf_c;
         end
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         ainv_q   <= 1'b0;
         binv_q   <= 1'b0;
         sop_q    <= SOP_AND;
         arith_q  <= 1'b0;
         slt_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         ainv_q   <= ainv_d;
         binv_q   <= binv_d;
         sop_q    <= sop_d;
         arith_q  <= arith_d;
         slt_q    <= slt_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign result          = result_q;
   assign zero            = zero_q;
   assign cout            = cout_q;
   assign overflow        = ovf_q;
   assign slice_src1      = op1_q[0];
   assign slice_src2      = op2_q[0];
   assign slice_less      = 1'b0;
   assign slice_a_invert  = ainv_q;
   assign slice_b_invert  = binv_q;
   assign slice_cin       = carry_q;
   assign slice_operation = sop_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl wired to an alu_top slice, checked against an arithmetic model.
module tb_alu_serial_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  src1 = '0;
   logic [W-1:0]  src2 = '0;
   logic [3:0]    alu_ctrl = 4'h0;
   logic          busy, done, zero, cout, overflow;
   logic [W-1:0]  result;
   logic          s_src1, s_src2, s_less, s_ainv, s_binv, s_cin;
   logic [1:0]    s_op;
   logic          s_result, s_cout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .src1(src1), .src2(src2), .alu_ctrl(alu_ctrl),
      .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout), .overflow(overflow),
      .slice_src1(s_src1), .slice_src2(s_src2), .slice_less(s_less),
      .slice_a_invert(s_ainv), .slice_b_invert(s_binv), .slice_cin(s_cin),
      .slice_operation(s_op), .slice_result(s_result), .slice_cout(s_cout)
   );

   alu_top u_slice (
      .src1(s_src1), .src2(s_src2), .less(s_less), .a_invert(s_ainv), .b_invert(s_binv),
      .cin(s_cin), .operation(s_op), .result(s_result), .cout(s_cout)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Reference: operation semantics from plain integer arithmetic
   function automatic void ref_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic z, output logic co,
                                  output logic ov);
      logic [W:0] s;
      longint sa, sb, d;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r = '0; co = 1'b0; ov = 1'b0;
      case (c)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0010: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[W-1:0];
            co = s[W];
            d  = sa + sb;
            ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
         end
         4'b0110, 4'b0111: begin
            r  = a - b;
            co = (a >= b);
            d  = sa - sb;
            ov = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            if (c == 4'b0111) r = (sa < sb) ? 32'd1 : 32'd0;
         end
         default: r = '0;
      endcase
      z = (r == '0);
   endfunction

   // Expected slice controls per code: {valid, a_invert, b_invert, cin0, op[1:0]}
   function automatic logic [5:0] drive_of(input logic [3:0] c);
      case (c)
         4'b0000: drive_of = 6'b1_0_0_0_00;
         4'b0001: drive_of = 6'b1_0_0_0_01;
         4'b0010: drive_of = 6'b1_0_0_0_10;
         4'b0110: drive_of = 6'b1_0_1_1_10;
         4'b0111: drive_of = 6'b1_0_1_1_10;
         4'b1100: drive_of = 6'b1_1_1_0_00;
         default: drive_of = 6'b0_0_0_0_00;
      endcase
   endfunction

   // Model state, advanced on each rising edge from the sampled inputs
   logic          m_run = 1'b0;
   int            m_acc = 0;
   int            m_done_at = -1;
   logic [W-1:0]  m_a = '0, m_b = '0;
   logic [3:0]    m_ctrl = 4'h0;
   logic [W-1:0]  p_res, m_res = '0;
   logic          p_z, p_c, p_v;
   logic          m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         m_run = 1'b0; m_done_at = -1;
         m_res = '0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
      end else if (m_run) begin
         if (cyc == m_acc + W) begin
            m_run = 1'b0; m_done_at = cyc;
            m_res = p_res; m_z = p_z; m_c = p_c; m_v = p_v;
         end
      end else if (start) begin
         m_run = 1'b1; m_acc = cyc;
         m_a = src1; m_b = src2; m_ctrl = alu_ctrl;
         ref_op(alu_ctrl, src1, src2, p_res, p_z, p_c, p_v);
      end
   end

   // Per-cycle comparison of every observable output against the model
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("busy", W'(busy), W'(m_run));
         chk("done", W'(done), W'(m_done_at == cyc));
         if (!m_run) begin
            chk("result", result, m_res);
            chk("flags", W'({zero, cout, overflow}), W'({m_z, m_c, m_v}));
            chk("slice_idle", W'({s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}), '0);
         end else begin
            int i;
            logic [5:0]  dv;
            logic [63:0] ea, eb, mask, s;
            i  = cyc - m_acc;
            dv = drive_of(m_ctrl);
            chk("slice_src", W'({s_src1, s_src2, s_less}), W'({m_a[i], m_b[i], 1'b0}));
            if (dv[5]) begin
               ea   = {32'd0, dv[4] ? ~m_a : m_a};
               eb   = {32'd0, dv[3] ? ~m_b : m_b};
               mask = (64'd1 << i) - 64'd1;
               s    = (ea & mask) + (eb & mask) + {63'd0, dv[2]};
               chk("slice_ctrl", W'({s_ainv, s_binv, s_op}), W'({dv[4], dv[3], dv[1:0]}));
               chk("slice_cin", W'(s_cin), W'(s[i]));
            end
         end
      end
   end

   int acc_cyc;

   task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; alu_ctrl = c; src1 = a; src2 = b;
      @(negedge clk);
      start = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_done(output int dc);
      logic found;
      found = 1'b0;
      dc = -1;
      for (int k = 0; k < W + 8; k++) begin
         @(negedge clk);
         if (done) begin found = 1'b1; dc = cyc; break; end
      end
      if (!found) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout at cycle %0d: got no done expected done", cyc);
      end
   endtask

   task automatic run_lit(input string nm, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                          input logic ec, input logic ev);
      int dc;
      issue(c, a, b);
      wait_done(dc);
      chk({nm, "_latency"}, W'(dc - acc_cyc), 32'd32);
      chk({nm, "_result"}, result, er);
      chk({nm, "_zcv"}, W'({zero, cout, overflow}), W'({ez, ec, ev}));
   endtask

   initial begin
      int d1, d2;
      logic [3:0]   codes [8];
      logic [W-1:0] corner [4];
      codes  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
      corner = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy_done", W'({busy, done}), '0);
      chk("reset_result", result, '0);
      chk("reset_flags", W'({zero, cout, overflow}), '0);

      run_lit("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      run_lit("sub_eq",  4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b1, 1'b0);
      run_lit("sub_neg", 4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      run_lit("slt_lt",  4'b0111, 32'hFFFF_FFFD, 32'd2, 32'd1, 1'b0, 1'b1, 1'b0);
      run_lit("slt_ovf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b1);
      run_lit("nor",     4'b1100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      run_lit("and",     4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
      run_lit("or",      4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
      run_lit("bad_code", 4'b0011, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);

      // Start request with new operands while running is ignored
      issue(4'b0010, 32'd100, 32'd23);
      repeat (5) @(negedge clk);
      start = 1'b1; alu_ctrl = 4'b0001; src1 = 32'hDEAD_BEEF; src2 = 32'h5555_5555;
      @(negedge clk);
      start = 1'b0;
      wait_done(d1);
      chk("busy_start_result", result, 32'd123);

      // Operand and code changes mid-run have no effect
      issue(4'b0110, 32'd1000, 32'd1);
      repeat (7) @(negedge clk);
      src1 = 32'hCAFE_F00D; src2 = 32'h0BAD_0BAD; alu_ctrl = 4'b1100;
      wait_done(d1);
      chk("midrun_src_result", result, 32'd999);

      // Start during the done cycle is accepted
      issue(4'b0010, 32'd10, 32'd20);
      wait_done(d1);
      start = 1'b1; alu_ctrl = 4'b0110; src1 = 32'd50; src2 = 32'd8;
      @(negedge clk);
      start = 1'b0;
      wait_done(d2);
      chk("b2b_spacing", W'(d2 - d1), 32'd33);
      chk("b2b_result", result, 32'd42);

      // Reset mid-run aborts without done
      issue(4'b0000, 32'hFFFF_FFFF, 32'h1234_5678);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_midrun_busy_done", W'({busy, done}), '0);
      chk("rst_midrun_result", result, '0);
      repeat (40) @(negedge clk);
      run_lit("add_after_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);

      // Reset wins over a simultaneous start
      @(negedge clk);
      rst = 1'b1; start = 1'b1; alu_ctrl = 4'b0010; src1 = 32'd1; src2 = 32'd1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", W'(busy), '0);
      repeat (3) @(negedge clk);

      // Randomised operations with input jitter while running
      for (int t = 0; t < 150; t++) begin
         logic found;
         logic [W-1:0] a, b;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
         issue(codes[$urandom_range(0, 7)], a, b);
         found = 1'b0;
         for (int k = 0; k < W + 8 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
            else begin
               src1 = W'($urandom); src2 = W'($urandom);
               alu_ctrl = 4'($urandom); start = 1'($urandom_range(0, 1));
            end
         end
         start = 1'b0;
         if (!found) begin
            n_tests++; n_fail++;
            $display("FAIL rand_timeout at cycle %0d: got no done expected done", cyc);
         end
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
